mux_n_pipe: RTL and testbench

- Parametrised N-input datapath selector with a registered, back-pressurable output stage, used for pipeline forwarding and writeback selection.
- Selects one of N_IN flattened inputs.
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer, so stalls never drop or duplicate data.
- Flags and counts out-of-range selects.

---
 rtl/mux_n_pipe_pkg.sv | 15 +
 rtl/mux_n_comb.sv | 27 ++
 rtl/mux_n_pipe.sv | 95 +++++++++
 tb/tb_mux_n_pipe.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_n_pipe_pkg.sv
// Shared constants and helpers for the N-input selector family.
package mux_n_pipe_pkg;

  // Largest supported input count.
  localparam int unsigned MUX_MAX_IN = 16;

  // Fill bit used to build the word returned for an out-of-range select.
  localparam logic ILLEGAL_FILL = 1'b0;

  // Select width for an n-input mux; never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_n_comb.sv
// Purely combinational N-input selector with an out-of-range flag.
module mux_n_comb
  import mux_n_pipe_pkg::*;
#(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned N_IN   = 3,
  localparam int unsigned SEL_W  = sel_width(N_IN)
) (
  input  logic [N_IN*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]       sel,
  output logic [DATA_W-1:0]      out_data,
  output logic                   illegal
);

  // Pick the matching input; a select that matches no input yields the fill word.
  always_comb begin
    out_data = {DATA_W{ILLEGAL_FILL}};
    illegal  = 1'b1;
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        out_data = in_data[k*DATA_W +: DATA_W];
        illegal  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_n_pipe.sv
// N-input selector with a registered valid/ready output stage backed by a
// one-entry skid register, plus an illegal-select pulse and saturating counter.
module mux_n_pipe
  import mux_n_pipe_pkg::*;
#(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned N_IN   = 3,
  parameter  int unsigned CNT_W  = 16,
  localparam int unsigned SEL_W  = sel_width(N_IN)
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic [N_IN*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   flush,
  output logic                   illegal_sel,
  output logic [CNT_W-1:0]       illegal_cnt
);

  logic [DATA_W-1:0] w_sel_data;
  logic              w_sel_illegal;
  logic              w_accept;
  logic              w_xfer;

  logic [DATA_W-1:0] r_main_data;
  logic              r_main_valid;
  logic [DATA_W-1:0] r_skid_data;
  logic              r_skid_valid;
  logic              r_illegal_sel;
  logic [CNT_W-1:0]  r_illegal_cnt;

  mux_n_comb #(
    .DATA_W (DATA_W),
    .N_IN   (N_IN)
  ) u_sel (
    .in_data  (in_data),
    .sel      (sel),
    .out_data (w_sel_data),
    .illegal  (w_sel_illegal)
  );

  // Ready depends only on skid occupancy, so there is no path from out_ready.
  assign in_ready    = !r_skid_valid;
  assign w_accept    = in_valid && in_ready;
  assign w_xfer      = r_main_valid && out_ready;

  assign out_data    = r_main_data;
  assign out_valid   = r_main_valid;
  assign illegal_sel = r_illegal_sel;
  assign illegal_cnt = r_illegal_cnt;

  // Main/skid occupancy: incoming beats go to main when it frees up, else to skid.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_main_data  <= '0;
      r_main_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_main_valid || (w_xfer && !r_skid_valid)) begin
      r_main_valid <= w_accept;
      if (w_accept) begin
        r_main_data <= w_sel_data;
      end
    end else if (w_xfer) begin
      // skid is full here, so in_ready was low and nothing was accepted
      r_main_data  <= r_skid_data;
      r_skid_valid <= 1'b0;
    end else if (w_accept) begin
      r_skid_data  <= w_sel_data;
      r_skid_valid <= 1'b1;
    end
  end

  // Illegal-select pulse and saturating count for accepted, non-flushed beats.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_illegal_sel <= 1'b0;
      r_illegal_cnt <= '0;
    end else begin
      r_illegal_sel <= w_accept && w_sel_illegal && !flush;
      if (w_accept && w_sel_illegal && !flush && (r_illegal_cnt != '1)) begin
        r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mux_n_pipe.sv
// Randomised self-checking bench for mux_n_pipe: the block is modelled as a
// two-deep FIFO of selected words with a separate illegal-beat counter.
module tb_mux_n_pipe;

  localparam int unsigned DW  = 32;
  localparam int unsigned NI  = 3;
  localparam int unsigned CW  = 4;
  localparam int unsigned CMAX = 15;

  logic           clk = 1'b0;
  logic           arst_n = 1'b0;
  logic [NI*DW-1:0] in_data = '0;
  logic [1:0]     sel = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [DW-1:0]  out_data;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic           flush = 1'b0;
  logic           illegal_sel;
  logic [CW-1:0]  illegal_cnt;

  int n_pass = 0;
  int n_tot  = 0;

  // model state
  logic [DW-1:0] q[$];
  bit            m_ill;
  int            m_cnt;
  bit            m_acc;

  mux_n_pipe #(
    .DATA_W (DW),
    .N_IN   (NI),
    .CNT_W  (CW)
  ) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .in_data     (in_data),
    .sel         (sel),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .flush       (flush),
    .illegal_sel (illegal_sel),
    .illegal_cnt (illegal_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [DW-1:0] pick(input logic [NI*DW-1:0] d, input int s);
    logic [NI*DW-1:0] t;
    if (s >= int'(NI)) return '0;
    t = d >> (s * DW);
    return t[DW-1:0];
  endfunction

  task automatic model_reset();
    q.delete();
    m_ill = 0;
    m_cnt = 0;
    m_acc = 0;
  endtask

  task automatic model_update();
    bit acc, xfer;
    if (!arst_n) begin
      model_reset();
      return;
    end
    acc  = in_valid && (q.size() < 2);
    xfer = (q.size() > 0) && out_ready;
    m_acc = acc;
    if (xfer) void'(q.pop_front());
    if (flush) q.delete();
    else if (acc) q.push_back(pick(in_data, int'(sel)));
    m_ill = acc && !flush && (int'(sel) >= int'(NI));
    if (m_ill && m_cnt < int'(CMAX)) m_cnt++;
  endtask

  task automatic compare_all();
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    if (q.size() > 0) chk("out_data", 64'(out_data), 64'(q[0]));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("illegal_sel", 64'(illegal_sel), 64'(m_ill));
    chk("illegal_cnt", 64'(illegal_cnt), 64'(m_cnt));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_in(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] c, input logic [1:0] s, input logic v);
    in_data  = {c, b, a};
    sel      = s;
    in_valid = v;
  endtask

  initial begin
    model_reset();

    // reset state
    cycle();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_illegal_sel", 64'(illegal_sel), 64'd0);
    chk("rst_illegal_cnt", 64'(illegal_cnt), 64'd0);
    arst_n = 1'b1;

    // streaming
    out_ready = 1'b1;
    set_in(32'hA, 32'hB, 32'hC, 2'd0, 1'b1);
    cycle();
    chk("stream_a", 64'(out_data), 64'hA);
    chk("stream_rdy0", 64'(in_ready), 64'd1);
    sel = 2'd1;
    cycle();
    chk("stream_b", 64'(out_data), 64'hB);
    sel = 2'd2;
    cycle();
    chk("stream_c", 64'(out_data), 64'hC);
    chk("stream_rdy2", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    cycle();

    // back-pressure
    out_ready = 1'b0;
    set_in(32'h11, 32'h0, 32'h0, 2'd0, 1'b1);
    cycle();
    set_in(32'h22, 32'h0, 32'h0, 2'd0, 1'b1);
    cycle();
    in_valid = 1'b0;
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_hold", 64'(out_data), 64'h11);
    cycle();
    chk("bp_hold2", 64'(out_data), 64'h11);
    out_ready = 1'b1;
    cycle();
    chk("bp_second", 64'(out_data), 64'h22);
    chk("bp_second_v", 64'(out_valid), 64'd1);
    cycle();
    chk("bp_drained", 64'(out_valid), 64'd0);

    // illegal select
    set_in(32'h11, 32'h22, 32'h33, 2'd3, 1'b1);
    cycle();
    chk("ill_data", 64'(out_data), 64'd0);
    chk("ill_pulse", 64'(illegal_sel), 64'd1);
    chk("ill_cnt", 64'(illegal_cnt), 64'd1);
    sel = 2'd2;
    cycle();
    chk("legal_data", 64'(out_data), 64'h33);
    chk("legal_nopulse", 64'(illegal_sel), 64'd0);
    in_valid = 1'b0;
    cycle();

    // counter saturation
    set_in(32'h1, 32'h2, 32'h3, 2'd3, 1'b1);
    repeat (20) cycle();
    in_valid = 1'b0;
    cycle();
    chk("sat_cnt", 64'(illegal_cnt), 64'd15);

    // asynchronous reset with beats buffered
    out_ready = 1'b0;
    set_in(32'h44, 32'h0, 32'h0, 2'd0, 1'b1);
    cycle();
    set_in(32'h55, 32'h0, 32'h0, 2'd0, 1'b1);
    cycle();
    in_valid = 1'b0;
    @(posedge clk);
    model_update();
    #2;
    arst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_cnt", 64'(illegal_cnt), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    compare_all();
    arst_n = 1'b1;

    // flush with skid full
    set_in(32'h44, 32'h0, 32'h0, 2'd0, 1'b1);
    cycle();
    set_in(32'h55, 32'h0, 32'h0, 2'd0, 1'b1);
    cycle();
    set_in(32'h66, 32'h0, 32'h0, 2'd3, 1'b1);
    flush = 1'b1;
    cycle();
    chk("flush_v", 64'(out_valid), 64'd0);
    chk("flush_rdy", 64'(in_ready), 64'd1);
    chk("flush_cnt", 64'(illegal_cnt), 64'd0);
    flush = 1'b0;
    in_valid = 1'b0;

    // flush discarding a simultaneously accepted illegal beat
    set_in(32'h77, 32'h0, 32'h0, 2'd0, 1'b1);
    cycle();
    set_in(32'h88, 32'h0, 32'h0, 2'd3, 1'b1);
    flush = 1'b1;
    cycle();
    chk("flush2_v", 64'(out_valid), 64'd0);
    chk("flush2_pulse", 64'(illegal_sel), 64'd0);
    chk("flush2_cnt", 64'(illegal_cnt), 64'd0);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    cycle();
    chk("flush2_gone", 64'(out_valid), 64'd0);

    // randomised traffic; upstream holds a beat until it is accepted
    for (int i = 0; i < 2000; i++) begin
      if (!(in_valid && !m_acc)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        sel      = 2'($urandom_range(0, 3));
        in_data  = {$urandom(), $urandom(), $urandom()};
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      cycle();
    end

    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (4) cycle();
    chk("final_empty", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
